// File: rtl/noc_router_xy_buffered_if.sv
// Flit bus of the 5-port XY router: per-port input and output valid/ready channels.
// Handshake: a flit moves on a channel at a rising clk edge where valid and ready are both 1;
// a producer keeps data stable while valid is high and ready is low.
interface noc_router_xy_buffered_if #(
    parameter int DATA_W = 256
);
    logic [5*DATA_W-1:0] in_data;
    logic [4:0]          in_valid;
    logic [4:0]          in_ready;
    logic [5*DATA_W-1:0] out_data;
    logic [4:0]          out_valid;
    logic [4:0]          out_ready;

    // Router side
    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid
    );

    // Neighbour / environment side
    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid
    );
endinterface

// File: rtl/noc_router_xy_buffered.sv
// 5-port buffered mesh router: per-input FIFOs, XY routing of FIFO heads,
// registered outputs with per-output round-robin arbitration.
// Port order everywhere: 0=E, 1=W, 2=N, 3=S, 4=IP.
module noc_router_xy_buffered #(
    parameter int DATA_W  = 256,
    parameter int COORD_W = 4,
    parameter int DEPTH   = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [COORD_W-1:0]  row,
    input  logic [COORD_W-1:0]  col,
    noc_router_xy_buffered_if.slave bus
);
    localparam int NP    = 5;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem     [NP][DEPTH];
    logic [PTR_W-1:0]  wr_ptr  [NP];
    logic [PTR_W-1:0]  rd_ptr  [NP];
    logic [CNT_W-1:0]  count   [NP];
    logic              ready_en;
    logic [NP-1:0]     in_ready_w;
    logic [NP-1:0]     push;
    logic [NP-1:0]     pop;
    logic [DATA_W-1:0] head    [NP];
    logic [NP-1:0]     req     [NP];   // req[input][output]
    logic [NP-1:0]     grant   [NP];   // grant[output][input]
    logic [NP-1:0]     out_grant;
    logic [2:0]        gnt_idx [NP];
    logic [DATA_W-1:0] gnt_data[NP];
    logic [2:0]        rr_ptr  [NP];
    logic [DATA_W-1:0] out_data_q [NP];
    logic [NP-1:0]     out_valid_q;
    logic [5*DATA_W-1:0] out_data_w;

    // One-hot output port for a head flit; column is resolved before row.
    function automatic logic [NP-1:0] xy_route(input logic [DATA_W-1:0] flit,
                                               input logic [COORD_W-1:0] my_row,
                                               input logic [COORD_W-1:0] my_col);
        logic [COORD_W-1:0] dst_row;
        logic [COORD_W-1:0] dst_col;
        dst_row = flit[DATA_W-1 -: COORD_W];
        dst_col = flit[DATA_W-1-COORD_W -: COORD_W];
        if (dst_col > my_col)      xy_route = 5'b00001;
        else if (dst_col < my_col) xy_route = 5'b00010;
        else if (dst_row > my_row) xy_route = 5'b01000;
        else if (dst_row < my_row) xy_route = 5'b00100;
        else                       xy_route = 5'b10000;
    endfunction

    // Input acceptance, FIFO heads and their routing requests.
    always_comb begin
        in_ready_w = '0;
        push       = '0;
        for (int p = 0; p < NP; p++) begin
            // Readiness comes from the registered count only, so a full FIFO refuses even while popping.
            in_ready_w[p] = ready_en && (count[p] != CNT_W'(DEPTH));
            push[p]       = bus.in_valid[p] & in_ready_w[p];
            head[p]       = mem[p][rd_ptr[p]];
            req[p]        = (count[p] != '0) ? xy_route(head[p], row, col) : '0;
        end
    end

    // Round-robin grant per free output, searching from the entry after the last winner.
    always_comb begin
        int idx;
        idx = 0;
        for (int o = 0; o < NP; o++) begin
            grant[o]     = '0;
            out_grant[o] = 1'b0;
            gnt_idx[o]   = 3'd0;
            gnt_data[o]  = '0;
            for (int i = 1; i <= NP; i++) begin
                idx = (int'(rr_ptr[o]) + i) % NP;
                if ((!out_valid_q[o] || bus.out_ready[o]) && !out_grant[o] && req[idx][o]) begin
                    grant[o][idx] = 1'b1;
                    out_grant[o]  = 1'b1;
                    gnt_idx[o]    = 3'(idx);
                    gnt_data[o]   = head[idx];
                end
            end
        end
    end

    // A head pops when any output granted it (a head requests exactly one output).
    always_comb begin
        pop = '0;
        for (int o = 0; o < NP; o++) begin
            pop = pop | grant[o];
        end
    end

    // FIFO storage; contents need no reset because pointers and counts are cleared.
    always_ff @(posedge clk) begin
        for (int p = 0; p < NP; p++) begin
            if (push[p]) mem[p][wr_ptr[p]] <= bus.in_data[p*DATA_W +: DATA_W];
        end
    end

    // FIFO pointers, occupancy and the post-reset input enable.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ready_en <= 1'b0;
            for (int p = 0; p < NP; p++) begin
                wr_ptr[p] <= '0;
                rd_ptr[p] <= '0;
                count[p]  <= '0;
            end
        end else begin
            ready_en <= 1'b1;
            for (int p = 0; p < NP; p++) begin
                if (push[p]) wr_ptr[p] <= wr_ptr[p] + PTR_W'(1);
                if (pop[p])  rd_ptr[p] <= rd_ptr[p] + PTR_W'(1);
                count[p] <= count[p] + CNT_W'(push[p]) - CNT_W'(pop[p]);
            end
        end
    end

    // Output registers and round-robin pointers; a busy output holds, a drained one clears valid only.
    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid_q <= '0;
            for (int o = 0; o < NP; o++) begin
                out_data_q[o] <= '0;
                rr_ptr[o]     <= 3'd4;
            end
        end else begin
            for (int o = 0; o < NP; o++) begin
                if (out_grant[o]) begin
                    out_data_q[o]  <= gnt_data[o];
                    out_valid_q[o] <= 1'b1;
                    rr_ptr[o]      <= gnt_idx[o];
                end else if (bus.out_ready[o]) begin
                    out_valid_q[o] <= 1'b0;
                end
            end
        end
    end

    // Flatten output registers onto the bus.
    always_comb begin
        out_data_w = '0;
        for (int o = 0; o < NP; o++) begin
            out_data_w[o*DATA_W +: DATA_W] = out_data_q[o];
        end
    end

    assign bus.out_data  = out_data_w;
    assign bus.out_valid = out_valid_q;
    assign bus.in_ready  = in_ready_w;
endmodule

// File: tb/tb_noc_router_xy_buffered.sv
// Bench for noc_router_xy_buffered: directed steps plus random traffic checked
// against a per-flow scoreboard built from the XY routing rule.
module tb_noc_router_xy_buffered;
    localparam int DATA_W  = 256;
    localparam int COORD_W = 4;
    localparam int DEPTH   = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic [COORD_W-1:0] row = '0;
    logic [COORD_W-1:0] col = '0;

    noc_router_xy_buffered_if #(.DATA_W(DATA_W)) bus();

    noc_router_xy_buffered #(.DATA_W(DATA_W), .COORD_W(COORD_W), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .row (row),
        .col (col),
        .bus (bus)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL timeout: bench did not finish within the time limit");
        $fatal(1, "timeout");
    end

    // ---------------- scoreboard ----------------
    int tests_run = 0;
    int fails     = 0;
    logic [DATA_W-1:0] exp_q[$];    // expected flits in acceptance order
    int                exp_key[$];  // src*5 + expected output port
    int deliv_cnt[5];
    int first_cyc[5];
    int last_cyc[5];
    int ip_log[$];
    int cyc = 0;
    logic [4:0] last_acc;

    task automatic chk(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
        tests_run++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Spec rule: column first (E if larger, W if smaller), then row (S if larger, N if smaller), else IP.
    function automatic int xy_dest(input int dr, input int dc, input int r, input int c);
        if (dc > c) return 0;
        if (dc < c) return 1;
        if (dr > r) return 3;
        if (dr < r) return 2;
        return 4;
    endfunction

    function automatic logic [DATA_W-1:0] mk_flit(input int dr, input int dc, input int src);
        logic [DATA_W-1:0] f;
        for (int w = 0; w < DATA_W/32; w++) f[w*32 +: 32] = $urandom;
        f[DATA_W-1 -: COORD_W]          = COORD_W'(dr);
        f[DATA_W-1-COORD_W -: COORD_W]  = COORD_W'(dc);
        f[2:0]                          = 3'(src);
        return f;
    endfunction

    // Output monitor: every completed output handshake must match the oldest pending flit of its flow.
    always @(negedge clk) begin
        logic [DATA_W-1:0] d;
        int s;
        int k;
        cyc++;
        if (rst) begin
            for (int o = 0; o < 5; o++) begin
                if (bus.out_valid[o] && bus.out_ready[o]) begin
                    d = bus.out_data[o*DATA_W +: DATA_W];
                    s = int'(d[2:0]);
                    k = -1;
                    for (int i = 0; i < exp_q.size(); i++)
                        if (k < 0 && exp_key[i] == s*5 + o) k = i;
                    tests_run++;
                    assert (k >= 0) else begin
                        fails++;
                        $error("FAIL sb_unexpected out=%0d got=%h exp=no_pending_flit_for_flow", o, d);
                    end
                    if (k >= 0) begin
                        chk($sformatf("sb_data_out%0d", o), d, exp_q[k]);
                        exp_q.delete(k);
                        exp_key.delete(k);
                    end
                    deliv_cnt[o]++;
                    if (first_cyc[o] < 0) first_cyc[o] = cyc;
                    last_cyc[o] = cyc;
                    if (o == 4) ip_log.push_back(s);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Drive one cycle of input flits; accepted ones enter the model. Entered and left at posedge+1.
    task automatic drive_cycle(input logic [4:0] vmask, input logic [5*DATA_W-1:0] flits);
        logic [4:0] acc;
        logic [DATA_W-1:0] f;
        bus.in_valid = vmask;
        bus.in_data  = flits;
        @(negedge clk);
        acc = vmask & bus.in_ready;
        for (int p = 0; p < 5; p++) begin
            if (acc[p]) begin
                f = flits[p*DATA_W +: DATA_W];
                exp_q.push_back(f);
                exp_key.push_back(p*5 + xy_dest(int'(f[DATA_W-1 -: COORD_W]),
                                                int'(f[DATA_W-1-COORD_W -: COORD_W]),
                                                int'(row), int'(col)));
            end
        end
        last_acc = acc;
        @(posedge clk);
        #1;
        bus.in_valid = '0;
    endtask

    task automatic send(input logic [4:0] mask, input int dr, input int dc);
        logic [5*DATA_W-1:0] pk;
        pk = '0;
        for (int p = 0; p < 5; p++) pk[p*DATA_W +: DATA_W] = mk_flit(dr, dc, p);
        drive_cycle(mask, pk);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Single flit from src; out_valid[dst] must be low after the push edge and high one edge later.
    task automatic lat_check(input int src, input int dr, input int dc, input int dst);
        logic [5*DATA_W-1:0] pk;
        logic [DATA_W-1:0] f;
        pk = '0;
        f  = mk_flit(dr, dc, src);
        pk[src*DATA_W +: DATA_W] = f;
        drive_cycle(5'(1 << src), pk);
        chk("lat_accept", last_acc[src], 1'b1);
        @(negedge clk);
        chk($sformatf("lat_t1_valid_out%0d", dst), bus.out_valid[dst], 1'b0);
        @(negedge clk);
        chk($sformatf("lat_t2_valid_out%0d", dst), bus.out_valid[dst], 1'b1);
        chk($sformatf("lat_t2_data_out%0d", dst), bus.out_data[dst*DATA_W +: DATA_W], f);
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed and random steps ----------------
    initial begin
        logic [5*DATA_W-1:0] pk;
        int accepted;
        int d0;
        int d1;
        int exp_log[7];

        for (int o = 0; o < 5; o++) begin
            deliv_cnt[o] = 0;
            first_cyc[o] = -1;
            last_cyc[o]  = -1;
        end
        bus.in_valid  = '0;
        bus.in_data   = '0;
        bus.out_ready = '0;
        row = 4'd1;
        col = 4'd1;

        // Reset held for two edges
        rst = 1'b0;
        idle(2);
        chk("rst_out_valid", bus.out_valid, '0);
        chk("rst_in_ready", bus.in_ready, '0);
        chk("rst_out_data", bus.out_data[DATA_W-1:0], '0);
        rst = 1'b1;
        idle(1);
        chk("post_rst_in_ready", bus.in_ready, 5'h1F);

        // Basic routes from the IP port with latency 2
        bus.out_ready = 5'h1F;
        lat_check(4, 1, 3, 0);
        idle(2);
        lat_check(4, 1, 1, 4);
        idle(2);
        lat_check(4, 0, 1, 2);
        idle(2);

        // Round-robin at the IP output (pointer left at 4 by the previous IP-out grant)
        ip_log.delete();
        send(5'b00111, 1, 1);
        idle(6);
        send(5'b00011, 1, 1);
        idle(6);
        send(5'b00101, 1, 1);
        idle(6);
        exp_log = '{0, 1, 2, 0, 1, 2, 0};
        chk("rr_log_size", 32'(ip_log.size()), 32'd7);
        for (int i = 0; i < 7; i++)
            if (i < ip_log.size()) chk($sformatf("rr_order_%0d", i), 32'(ip_log[i]), 32'(exp_log[i]));

        // Backpressure on W output: output register plus DEPTH FIFO entries, then refusal
        bus.out_ready = 5'b11101;
        d1 = deliv_cnt[1];
        accepted = 0;
        for (int i = 0; i < 8; i++) begin
            send(5'b10000, 1, 0);
            if (last_acc[4]) accepted++;
        end
        chk("bp_accepted", 32'(accepted), 32'(DEPTH + 1));
        chk("bp_in_ready_low", bus.in_ready[4], 1'b0);
        chk("bp_no_delivery", 32'(deliv_cnt[1] - d1), 32'd0);
        chk("bp_out_valid_held", bus.out_valid[1], 1'b1);
        bus.out_ready = 5'h1F;
        idle(10);
        chk("bp_drained_count", 32'(deliv_cnt[1] - d1), 32'(DEPTH + 1));
        chk("bp_sb_empty", 32'(exp_q.size()), 32'd0);

        // Concurrent streams E->IP and W->N at full rate
        d0 = deliv_cnt[4];
        d1 = deliv_cnt[2];
        first_cyc[4] = -1;
        first_cyc[2] = -1;
        accepted = 0;
        for (int i = 0; i < 8; i++) begin
            pk = '0;
            pk[0*DATA_W +: DATA_W] = mk_flit(1, 1, 0);
            pk[1*DATA_W +: DATA_W] = mk_flit(0, 1, 1);
            drive_cycle(5'b00011, pk);
            accepted += int'(last_acc[0]) + int'(last_acc[1]);
        end
        idle(4);
        chk("tp_accepted", 32'(accepted), 32'd16);
        chk("tp_ip_count", 32'(deliv_cnt[4] - d0), 32'd8);
        chk("tp_n_count", 32'(deliv_cnt[2] - d1), 32'd8);
        chk("tp_ip_span", 32'(last_cyc[4] - first_cyc[4]), 32'd7);
        chk("tp_n_span", 32'(last_cyc[2] - first_cyc[2]), 32'd7);
        chk("tp_parallel_start", 32'(first_cyc[4]), 32'(first_cyc[2]));

        // Reset with flits buffered drops everything
        bus.out_ready = '0;
        send(5'b10000, 1, 3);
        send(5'b10000, 1, 3);
        send(5'b10000, 1, 3);
        idle(1);
        rst = 1'b0;
        exp_q.delete();
        exp_key.delete();
        idle(2);
        chk("mid_rst_out_valid", bus.out_valid, '0);
        chk("mid_rst_in_ready", bus.in_ready, '0);
        rst = 1'b1;
        idle(1);
        chk("mid_rst_release_in_ready", bus.in_ready, 5'h1F);
        chk("mid_rst_release_out_valid", bus.out_valid, '0);
        bus.out_ready = 5'h1F;
        d0 = deliv_cnt[0];
        idle(5);
        chk("mid_rst_fifo_empty", 32'(deliv_cnt[0] - d0), 32'd0);
        chk("mid_rst_out_valid_idle", bus.out_valid, '0);
        lat_check(4, 1, 3, 0);
        idle(2);

        // Random traffic with random backpressure at two tile positions
        for (int ph = 0; ph < 2; ph++) begin
            row = COORD_W'($urandom_range(0, 15));
            col = COORD_W'($urandom_range(0, 15));
            for (int i = 0; i < 300; i++) begin
                bus.out_ready = 5'($urandom);
                pk = '0;
                for (int p = 0; p < 5; p++)
                    pk[p*DATA_W +: DATA_W] = mk_flit($urandom_range(0, 15), $urandom_range(0, 15), p);
                drive_cycle(5'($urandom), pk);
            end
            bus.out_ready = 5'h1F;
            idle(30);
            chk($sformatf("rand_sb_empty_%0d", ph), 32'(exp_q.size()), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end
endmodule
